// File: rtl/adder_pkg.sv
// Shared types and default sizing for the serial adder slice.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_CHUNK = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry entering its MSB
// so the caller can derive two's-complement overflow on the final slice.
module chunk_adder #(
    parameter int unsigned CHUNK = 1
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out,
    output logic             carry_msb
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = carry_in;
        for (int i = 0; i < int'(CHUNK); i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
    end

    assign carry_out = carry[CHUNK];
    assign carry_msb = carry[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder processing CHUNK bits per cycle, LSB slice first.
// Optional SERIAL_ADDER_SUBTRACT_EN adds an i_subtract port sampled at accept.
module serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_augend,
    input  logic [WIDTH-1:0] i_addend,
    input  logic             i_carry,
`ifdef SERIAL_ADDER_SUBTRACT_EN
    input  logic             i_subtract,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int unsigned STEPS = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("serial_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_e             state_q;
    logic [WIDTH-1:0]   aug_q;
    logic [WIDTH-1:0]   add_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               sub;
    logic [WIDTH-1:0]   addend_eff;
    logic               carry_in_eff;
    logic [CHUNK-1:0]   slice_sum;
    logic               slice_cout;
    logic               slice_cmsb;

`ifdef SERIAL_ADDER_SUBTRACT_EN
    assign sub = i_subtract;
`else
    assign sub = 1'b0;
`endif

    // Subtraction is a + ~b + ~borrow, folded in once at accept time.
    assign addend_eff   = i_addend ^ {WIDTH{sub}};
    assign carry_in_eff = i_carry ^ sub;

    // Operands shift right each step, so the active slice is always at bit 0.
    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a         (aug_q[CHUNK-1:0]),
        .b         (add_q[CHUNK-1:0]),
        .carry_in  (carry_q),
        .sum       (slice_sum),
        .carry_out (slice_cout),
        .carry_msb (slice_cmsb)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            aug_q      <= '0;
            add_q      <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        aug_q   <= i_augend;
                        add_q   <= addend_eff;
                        carry_q <= carry_in_eff;
                        cnt_q   <= '0;
                        o_ready <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    aug_q   <= aug_q >> CHUNK;
                    add_q   <= add_q >> CHUNK;
                    sum_q   <= WIDTH'({slice_sum, sum_q} >> CHUNK);
                    carry_q <= slice_cout;
                    if (cnt_q == CNT_W'(STEPS - 1)) begin
                        o_carry    <= slice_cout;
                        o_overflow <= slice_cmsb ^ slice_cout;
                        o_valid    <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_sum = sum_q;

endmodule
